// File: rtl/riot_input_conditioner.sv
// riot_input_conditioner
// Conditions raw controller and console-switch inputs for the M6532 RIOT
// port-A/port-B input buses and the TIA paddle-button/fire lines.
//   - per-bit debounce (DEBOUNCE_CYCLES ce ticks, 0 = single register stage)
//   - minimum-width stretch of reset/select/pause taps (HOLD_CYCLES ce ticks)
//   - fire-button routing by the 7800 one-/two-button mode read from PB_out
// Optional feature macro: RIOT_INPUT_SOCD_EN
//   defined   -> opposing directions held together are reported released
//   undefined -> directions pass through unmodified
// All state advances only on clk with ce high; res_n is asynchronous active-low.

module riot_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       ce,
  input  logic [3:0] joy0,
  input  logic [3:0] joy1,
  input  logic [1:0] btn0,
  input  logic [1:0] btn1,
  input  logic       sw_reset,
  input  logic       sw_select,
  input  logic       sw_pause,
  input  logic       diff_l,
  input  logic       diff_r,
  input  logic [7:0] pb_out,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic [3:0] inpt,
  output logic [1:0] fire_n
);

  localparam int          NB     = 17;
  localparam logic [15:0] HOLD16 = 16'(HOLD_CYCLES);

  // Bit map of the conditioned vector:
  //   [3:0] joy0 {R,L,D,U}   [7:4] joy1 {R,L,D,U}
  //   [9:8] btn0 {left,right} [11:10] btn1 {left,right}
  //   [12] reset [13] select [14] pause [15] diff_l [16] diff_r
  logic [NB-1:0] w_raw;
  logic [NB-1:0] w_stable_nxt;
  logic [NB-1:0] r_stable;

  assign w_raw = {diff_r, diff_l, sw_pause, sw_select, sw_reset,
                  btn1, btn0, joy1, joy0};

  // Only PB_out bits 2 and 4 carry the button-mode flags.
  logic w_unused;
  assign w_unused = &{1'b0, pb_out[7:5], pb_out[3], pb_out[1:0]};

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // Bypass: the stable register itself is the single input stage.
    assign w_stable_nxt = w_raw;
  end else begin : g_debounce
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    logic [NB-1:0] r_in;

    // Input register stage ahead of the debounce counters.
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)  r_in <= '0;
      else if (ce) r_in <= w_raw;
    end

    for (genvar i = 0; i < NB; i++) begin : g_bit
      logic [15:0] r_cnt;
      logic        w_accept;

      // The tick that would bring the counter to DEBOUNCE_CYCLES accepts raw.
      assign w_accept        = (r_in[i] != r_stable[i]) && (r_cnt == DB_LAST);
      assign w_stable_nxt[i] = w_accept ? r_in[i] : r_stable[i];

      // Count consecutive ticks of disagreement; clear on agreement or accept.
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          r_cnt <= '0;
        end else if (ce) begin
          if ((r_in[i] == r_stable[i]) || w_accept) r_cnt <= '0;
          else                                      r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  // Debounced stable levels.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)  r_stable <= '0;
    else if (ce) r_stable <= w_stable_nxt;
  end

  // Console switch stretch: effective = stable | (hold counter running).
  logic [2:0] w_sw_eff;

  for (genvar k = 0; k < 3; k++) begin : g_hold
    logic [15:0] r_hold;
    logic        w_rise;

    assign w_rise      = w_stable_nxt[12+k] & ~r_stable[12+k];
    assign w_sw_eff[k] = r_stable[12+k] | (r_hold != 16'd0);

    // Load on a stable rising edge (also on re-press), else count down to 0.
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        r_hold <= '0;
      end else if (ce) begin
        if (w_rise)                r_hold <= HOLD16;
        else if (r_hold != 16'd0)  r_hold <= r_hold - 16'd1;
      end
    end
  end

  // Per-player opposing-direction cleanup on {R,L,D,U}.
  function automatic logic [3:0] socd_clean(input logic [3:0] d);
    logic [3:0] c;
    c = d;
`ifdef RIOT_INPUT_SOCD_EN
    if (d[3] && d[2]) c[3:2] = 2'b00;
    if (d[1] && d[0]) c[1:0] = 2'b00;
`endif
    return c;
  endfunction

  logic [3:0] w_dir0;
  logic [3:0] w_dir1;
  logic [7:0] w_pa_nxt;
  logic [7:0] w_pb_nxt;
  logic [3:0] w_inpt_nxt;
  logic [1:0] w_fire_nxt;

  assign w_dir0 = socd_clean(r_stable[3:0]);
  assign w_dir1 = socd_clean(r_stable[7:4]);

  // Next values of the port buses and the TIA button lines.
  always_comb begin
    w_pa_nxt   = ~{w_dir0, w_dir1};
    w_pb_nxt   = {~r_stable[16], ~r_stable[15], 1'b1, pb_out[4],
                  ~w_sw_eff[2], pb_out[2], ~w_sw_eff[1], ~w_sw_eff[0]};
    w_inpt_nxt = 4'b0000;
    w_fire_nxt = 2'b11;
    // Player 0: mode bit pb_out[2], 1 = one-button.
    if (pb_out[2]) begin
      w_fire_nxt[0] = ~(r_stable[9] | r_stable[8]);
    end else begin
      w_inpt_nxt[0] = r_stable[8];
      w_inpt_nxt[1] = r_stable[9];
    end
    // Player 1: mode bit pb_out[4], 1 = one-button.
    if (pb_out[4]) begin
      w_fire_nxt[1] = ~(r_stable[11] | r_stable[10]);
    end else begin
      w_inpt_nxt[2] = r_stable[10];
      w_inpt_nxt[3] = r_stable[11];
    end
  end

  // Registered outputs; reset drives the released/idle levels immediately.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pa_in  <= 8'hFF;
      pb_in  <= 8'hFF;
      inpt   <= 4'b0000;
      fire_n <= 2'b11;
    end else if (ce) begin
      pa_in  <= w_pa_nxt;
      pb_in  <= w_pb_nxt;
      inpt   <= w_inpt_nxt;
      fire_n <= w_fire_nxt;
    end
  end

endmodule

// File: tb/tb_riot_input_conditioner.sv
// Directed testbench for riot_input_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16).
// Expected values are hand-derived tick counts measured from the first posedge
// that samples a newly driven input (tick 1).

module tb_riot_input_conditioner;

  logic       clk = 1'b0;
  logic       res_n;
  logic       ce;
  logic [3:0] joy0, joy1;
  logic [1:0] btn0, btn1;
  logic       sw_reset, sw_select, sw_pause, diff_l, diff_r;
  logic [7:0] pb_out;
  logic [7:0] pa_in, pb_in;
  logic [3:0] inpt;
  logic [1:0] fire_n;

  int n_checks = 0;
  int n_errors = 0;

  riot_input_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk(clk), .res_n(res_n), .ce(ce),
    .joy0(joy0), .joy1(joy1), .btn0(btn0), .btn1(btn1),
    .sw_reset(sw_reset), .sw_select(sw_select), .sw_pause(sw_pause),
    .diff_l(diff_l), .diff_r(diff_r), .pb_out(pb_out),
    .pa_in(pa_in), .pb_in(pb_in), .inpt(inpt), .fire_n(fire_n)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance n posedges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic all_inputs(input logic v);
    joy0 = {4{v}}; joy1 = {4{v}}; btn0 = {2{v}}; btn1 = {2{v}};
    sw_reset = v; sw_select = v; sw_pause = v; diff_l = v; diff_r = v;
  endtask

  logic [7:0] exp_pa_all;
  logic [7:0] exp_pa_socd;
  logic [1:0] exp_pa_ud;

  initial begin
`ifdef RIOT_INPUT_SOCD_EN
    exp_pa_all  = 8'hFF;  // every opposite pair held -> all released
    exp_pa_socd = 8'hEF;  // joy0 R+L+U -> only U remains
    exp_pa_ud   = 2'b11;
`else
    exp_pa_all  = 8'h00;
    exp_pa_socd = 8'h2F;  // joy0 = 1101 inverted, joy1 idle
    exp_pa_ud   = 2'b00;
`endif

    // Reset with all inputs high
    res_n = 1'b0; ce = 1'b1; pb_out = 8'hFF;
    all_inputs(1'b1);
    tick(2);
    check("rst_pa_in",  {24'd0, pa_in},  32'hFF);
    check("rst_pb_in",  {24'd0, pb_in},  32'hFF);
    check("rst_inpt",   {28'd0, inpt},   32'h0);
    check("rst_fire_n", {30'd0, fire_n}, 32'h3);

    // Release with all inputs still high, pb_out = 0
    pb_out = 8'h00;
    res_n  = 1'b1;
    tick(5);
    check("settle_pb_t5", {24'd0, pb_in}, 32'hEB);
    tick(1);
    check("settle_pb_t6", {24'd0, pb_in}, 32'h20);
    check("settle_pa",    {24'd0, pa_in}, {24'd0, exp_pa_all});
    check("settle_inpt",  {28'd0, inpt},  32'hF);
    check("settle_fire",  {30'd0, fire_n}, 32'h3);

    // Everything released, wait out debounce and hold stretch
    all_inputs(1'b0);
    tick(30);
    check("idle_pa",   {24'd0, pa_in},  32'hFF);
    check("idle_pb",   {24'd0, pb_in},  32'hEB);
    check("idle_inpt", {28'd0, inpt},   32'h0);
    check("idle_fire", {30'd0, fire_n}, 32'h3);

    // Glitch of 3 ticks on joy0[3] never reaches pa_in[7]
    joy0 = 4'b1000;
    tick(3);
    joy0 = 4'b0000;
    for (int t = 0; t < 8; t++) begin
      tick(1);
      check("glitch_pa7", {31'd0, pa_in[7]}, 32'd1);
    end

    // Held joy0[3]: pa_in[7] falls exactly on tick 6
    joy0 = 4'b1000;
    tick(5);
    check("joy_t5_pa7", {31'd0, pa_in[7]}, 32'd1);
    tick(1);
    check("joy_t6_pa7", {31'd0, pa_in[7]}, 32'd0);
    joy0 = 4'b0000;
    tick(10);
    check("joy_rel_pa", {24'd0, pa_in}, 32'hFF);

    // Select tap of 5 ticks: pb_in[1] low on ticks 6..21 (16 ticks)
    sw_select = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick(1);
      if (t == 5) sw_select = 1'b0;
      check("hold_sel", {31'd0, pb_in[1]}, (t >= 6 && t <= 21) ? 32'd0 : 32'd1);
    end
    tick(10);

    // Re-press: raw high ticks 1-5 and 10-14. Stable rises at 5 and 14,
    // reload at 14 keeps pb_in[1] low on ticks 6..30.
    sw_select = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      tick(1);
      if (t == 5)  sw_select = 1'b0;
      if (t == 9)  sw_select = 1'b1;
      if (t == 14) sw_select = 1'b0;
      check("repress_sel", {31'd0, pb_in[1]}, (t >= 6 && t <= 30) ? 32'd0 : 32'd1);
    end
    tick(10);

    // Button modes
    btn0 = 2'b01;  // P0 right
    btn1 = 2'b10;  // P1 left
    pb_out = 8'h14;
    tick(7);
    check("one_btn_fire", {30'd0, fire_n}, 32'h0);
    check("one_btn_inpt", {28'd0, inpt},   32'h0);
    check("one_btn_pb",   {24'd0, pb_in},  32'hFF);
    pb_out = 8'h10;
    tick(1);
    check("p0_two_fire", {30'd0, fire_n}, 32'h1);
    check("p0_two_inpt", {28'd0, inpt},   32'h1);
    check("p0_two_pb",   {24'd0, pb_in},  32'hFB);
    pb_out = 8'h00;
    tick(1);
    check("both_two_fire", {30'd0, fire_n}, 32'h3);
    check("both_two_inpt", {28'd0, inpt},   32'h9);

    // ce low freezes outputs
    ce = 1'b0;
    pb_out = 8'h14;
    tick(3);
    check("ce_freeze_fire", {30'd0, fire_n}, 32'h3);
    check("ce_freeze_inpt", {28'd0, inpt},   32'h9);
    ce = 1'b1;
    tick(1);
    check("ce_resume_fire", {30'd0, fire_n}, 32'h0);
    check("ce_resume_inpt", {28'd0, inpt},   32'h0);
    btn0 = 2'b00; btn1 = 2'b00; pb_out = 8'h00;
    tick(8);

    // Opposing directions
    joy0 = 4'b1100;
    tick(7);
    check("socd_lr", {30'd0, pa_in[7:6]}, {30'd0, exp_pa_ud});
    joy0 = 4'b1101;
    tick(7);
    check("socd_axis", {24'd0, pa_in}, {24'd0, exp_pa_socd});
    joy0 = 4'b0000;
    joy1 = 4'b0011;
    tick(7);
    check("socd_ud", {30'd0, pa_in[1:0]}, {30'd0, exp_pa_ud});
    joy1 = 4'b0000;
    tick(8);

    // Reset mid-hold: stable edge at tick 5, counter at 8 after tick 13
    sw_reset = 1'b1;
    tick(5);
    sw_reset = 1'b0;
    tick(8);
    check("pre_rst_pb0", {31'd0, pb_in[0]}, 32'd0);
    res_n = 1'b0;
    #1;
    check("midhold_rst_pb", {24'd0, pb_in}, 32'hFF);
    tick(2);
    res_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      check("post_rst_pb0", {31'd0, pb_in[0]}, 32'd1);
    end
    check("post_rst_pb", {24'd0, pb_in}, 32'hEB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riot_input_conditioner.md
# riot_input_conditioner

Conditions raw host controller and console-switch inputs into the port-A and port-B input buses of the M6532 RIOT, plus the TIA fire/paddle-button lines. It debounces every input and stretches short console-switch taps to a minimum width. It also routes the fire buttons according to the 7800 one-/two-button mode that the RIOT drives on PB_out. It sits directly upstream of the RIOT: its `pa_in`/`pb_in` feed the RIOT's `PA_in`/`PB_in`, and it reads the RIOT's `PB_out` back.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive `ce` ticks an input must hold a new level before it is accepted. 0 = bypass, one register stage only. Legal range 0..65535.
- HOLD_CYCLES, 16: minimum asserted width, in `ce` ticks, of reset/select/pause. Legal range 1..65535.

Ports (clock and reset first):
- clk  in  1  system clock (PHI 2 domain)
- res_n  in  1  reset; one clock, reset asynchronous active-low
- ce  in  1  clock enable; all state advances only when high
- joy0  in  4  player 0 {right,left,down,up}, active-high
- joy1  in  4  player 1 {right,left,down,up}, active-high
- btn0  in  2  player 0 {left,right} fire, active-high
- btn1  in  2  player 1 {left,right} fire, active-high
- sw_reset, sw_select, sw_pause  in  1 each  console switches, active-high, momentary
- diff_l, diff_r  in  1 each  difficulty switches, level (1 = A/pro)
- pb_out  in  8  RIOT PB_out readback
- pa_in  out  8  to RIOT PA_in, active-low
- pb_in  out  8  to RIOT PB_in
- inpt  out  4  TIA INPT0..3, active-high paddle-button lines
- fire_n  out  2  TIA INPT4 (bit 0, P0) and INPT5 (bit 1, P1), active-low

## Operation
- Debounce:
  - Applies to 17 bits: 8 directions, 4 buttons, 3 console switches, 2 difficulty bits.
  - Each bit has a stable value and a 16-bit counter.
  - On each `ce`, if raw ≠ stable, the counter increments. When the counter reaches DEBOUNCE_CYCLES, stable takes raw and the counter clears. If raw = stable, the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES ticks never reaches the outputs.
- Hold stretch (reset/select/pause):
  - On a stable 0→1 edge, a 16-bit hold counter loads HOLD_CYCLES.
  - Each `ce` with the counter nonzero decrements it.
  - Effective switch = stable | (counter ≠ 0).
  - A re-press while the counter is nonzero reloads the counter.
- pa_in: {~R0,~L0,~D0,~U0,~R1,~L1,~D1,~U1}, built from the stable directions (after SOCD, see Configuration).
- pb_in:
  - bit0 = ~reset, bit1 = ~select, bit3 = ~pause.
  - bit6 = ~diff_l, bit7 = ~diff_r.
  - bit2 = pb_out[2], bit4 = pb_out[4], bit5 = 1.
- Button routing, per player p (p0 mode bit = pb_out[2], p1 mode bit = pb_out[4]):
  - One-button mode (mode bit = 1): fire_n[p] = ~(left|right); inpt[2p+1:2p] = 0.
  - Two-button mode (mode bit = 0): fire_n[p] = 1; inpt[2p] = right; inpt[2p+1] = left.

## Timing
- All outputs are registered and update on `clk` with `ce` high. `ce` low freezes all state and outputs.
- Latency from a raw change to the output:
  - DEBOUNCE_CYCLES = 0: 2 `ce` ticks (input register + output register).
  - Otherwise: DEBOUNCE_CYCLES + 2 ticks.
- pb_out to pb_in[2]/[4]/inpt/fire_n: 1 `ce` tick. No debounce on pb_out.
- Reset (async assert, outputs valid immediately):
  - All stable bits = 0 and all counters = 0.
  - pa_in = 8'hFF, pb_in = 8'hFF, inpt = 0, fire_n = 2'b11.
- Reset during a hold cancels the stretch; the switch reads released on the first output update after release.
- A stable falling edge while the hold counter is nonzero keeps the switch asserted until the counter reaches 0.

## Configuration
- Macro RIOT_INPUT_SOCD_EN.
- Defined: opposing directions are cleaned per player after debounce. Left+right stable together → both reported released; up+down → both released. The other axis is unaffected.
- Undefined: directions pass through unmodified, so pa_in may show both opposites low.

## Test plan
- Reset values: hold res_n=0 with all inputs high → pa_in=8'hFF, pb_in=8'hFF, inpt=0, fire_n=2'b11. Release res_n → pb_in settles to 8'h20 after DEBOUNCE_CYCLES+2 ticks (pb_out=0).
- Glitch rejection: DEBOUNCE_CYCLES=4, pulse joy0[3] high for 3 `ce` ticks → pa_in[7] stays 1. Hold it 4+ ticks → pa_in[7]=0 exactly 6 ticks after the rise.
- Hold stretch: HOLD_CYCLES=16, sw_select pulsed for 5 ticks → pb_in[1]=0 for exactly 16 ticks. A re-press at tick 10 extends the low time to tick 10+16 from the first assertion of the stable edge.
- Button modes: pb_out=8'h14, btn0=2'b01 → fire_n[0]=0, inpt[1:0]=0. Set pb_out[2]=0 → next tick fire_n[0]=1, inpt[0]=1, inpt[1]=0.
- SOCD: joy0=4'b1100. With RIOT_INPUT_SOCD_EN → pa_in[7:6]=2'b11; without → 2'b00.
- Reset mid-hold: assert res_n=0 at hold count 8 → pb_in[0]=1 immediately. After release with sw_reset=0, it stays 1.
